stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
Sequencer for the stack_top register-array pair in the CCM.
- Accepts a stream of column beats from upstream via valid/ready.
- Drives the shared en/col bus of both stacks.
- Tracks column/row position across a frame.
- Tells downstream when a full KERNEL-row window is available, with the column it belongs to.

Parameters:
- KERNEL, 3, rows per window; rows 0..KERNEL-2 only prime the stacks.
- COL_W, 9, width of col and of the cfg_width/cfg_height fields; matches the stack_top col port.
- RD_LAT, 1, stack buf_out latency in cycles after en; fixed at 1 in this revision.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame, samples cfg_*
- cfg_width  in  COL_W  columns per row (1..511)
- cfg_height  in  COL_W  rows per frame (KERNEL..511)
- in_valid  in  1  upstream beat valid (data goes straight to stack_top buf_in1/2)
- in_ready  out  1  beat accepted when in_valid && in_ready
- stk_en  out  1  to stack_top en
- stk_col  out  COL_W  to stack_top col
- out_valid  out  1  window column available on stack_top buf_out1/2
- out_ready  in  1  downstream accepts window column
- out_col  out  COL_W  column index of the presented window
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last window column is accepted
- cfg_err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset values: in_ready=0, stk_en=0, stk_col=0, out_valid=0, out_col=0, busy=0, frame_done=0, cfg_err=0. State=IDLE; counters are 0.
- State machine:
  - IDLE: on start, if cfg_width==0 or cfg_height<KERNEL, pulse cfg_err and stay in IDLE. Otherwise latch cfg into w_r/h_r, clear col_cnt/row_cnt, go to FILL.
  - FILL: row_cnt < KERNEL-1. in_ready=1. The last beat of row KERNEL-2 moves to RUN.
  - RUN: in_ready = !out_valid || out_ready (one-entry output stage). The last beat of row h_r-1 moves to DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready (or out_valid already 0), pulse frame_done next cycle and go to IDLE.
- A start pulse outside IDLE is ignored; no cfg_err is raised.
- busy=1 in FILL, RUN and DRAIN.
- Per-beat accept:
  - stk_en = in_valid && in_ready, combinational, same cycle.
  - stk_col = col_cnt, registered.
  - col_cnt increments on accept. It wraps from w_r-1 to 0, and row_cnt increments on the wrap.
- Output stage:
  - On an accept in RUN, out_valid is set on the next edge (RD_LAT=1) and out_col = the accepted col_cnt.
  - out_valid clears on out_valid && out_ready unless a new accept loads it in the same cycle. Simultaneous load and drain keeps out_valid=1 with the new out_col.
- No beats are accepted in FILL-to-RUN bubbles; there are none, and the transition is zero-cycle.
- Single-column frame: w_r==1 gives col always 0, and every beat is a row wrap.
- Reset mid-frame: all state returns to the reset values asynchronously; stack contents are not cleared by this block.

Optional Feature:
- Macro STACK_CTRL_PERF_EN.
- Defined: adds output stall_cnt[15:0] and output bp_cnt[15:0].
  - stall_cnt counts cycles with busy && !in_valid && in_ready.
  - bp_cnt counts cycles with out_valid && !out_ready.
  - Both clear on an accepted start, saturate at 16'hFFFF, and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package entry in para.v:
  - state encodings S_IDLE=2'd0, S_FILL=2'd1, S_RUN=2'd2, S_DRAIN=2'd3;
  - `KERNEL and `COL_W defaults.
- One natural sub-module, stack_pos_cnt: col/row counter with wrap, row_last and frame_last flags.
- The FSM and output stage remain in stack_ctrl.

Test Plan:
1. Reset mid-RUN (rst_n low 1 cycle at row 3, col 5) -> all outputs 0 asynchronously; IDLE; the next start runs a clean frame.
2. Config error:
   - start with cfg_width=0 -> cfg_err pulse for 1 cycle, busy stays 0.
   - start with cfg_height=2, KERNEL=3 -> same response.
3. Nominal frame: cfg_width=4, cfg_height=4, in_valid=1 and out_ready=1 continuously.
   - stk_col sequence 0,1,2,3 repeated ×4 (16 stk_en).
   - out_valid for the 8 beats of rows 2–3, out_col 0..3,0..3.
   - frame_done exactly 1 cycle after the last out accept.
4. Backpressure: same frame, out_ready low for 5 cycles mid-row-2 -> in_ready low, stk_en low, out_col held; no beat lost or duplicated; bp_cnt=5 with STACK_CTRL_PERF_EN.
5. Upstream gaps: in_valid toggling 1,0,1,0 in FILL -> col_cnt advances only on accepts; stall_cnt increments on the gap cycles.
6. Edge config: cfg_width=1, cfg_height=3 -> stk_col always 0, exactly 1 out_valid beat with out_col=0, then frame_done; start during busy is ignored.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared constants and FSM encoding for the stack_top sequencer.
package stack_ctrl_pkg;
    localparam int STK_KERNEL = 3;
    localparam int STK_COL_W  = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/stack_pos_cnt.sv
// Column/row position counter for one frame; col wraps at width-1 and bumps row.
// Latency: position is registered, flags are combinational from it.
// Backpressure: advances only on inc, so stalls simply hold the position.
module stack_pos_cnt #(
    parameter int COL_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [COL_W-1:0] width,
    input  logic [COL_W-1:0] height,
    output logic [COL_W-1:0] col,
    output logic [COL_W-1:0] row,
    output logic             row_last,
    output logic             frame_last
);
    localparam logic [COL_W-1:0] ONE = COL_W'(1);

    assign row_last   = (col == width - ONE);
    assign frame_last = row_last && (row == height - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (row_last) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end
endmodule

// File: rtl/stack_ctrl.sv
// Sequencer for the stack_top pair: accepts column beats, drives en/col, presents KERNEL-row windows.
// Latency: stk_en same cycle as accept; out_valid one cycle after accept (buf_out read latency 1).
// Backpressure: one-entry output stage, in_ready drops while it is full and out_ready is low.
// Optional STACK_CTRL_PERF_EN adds stall_cnt / bp_cnt counters.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int KERNEL = STK_KERNEL,
    parameter int COL_W  = STK_COL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [COL_W-1:0] cfg_width,
    input  logic [COL_W-1:0] cfg_height,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             stk_en,
    output logic [COL_W-1:0] stk_col,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
`ifdef STACK_CTRL_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      bp_cnt
`endif
);
    localparam logic [COL_W-1:0] KMIN     = COL_W'(KERNEL);
    localparam logic [COL_W-1:0] FILL_ROW = COL_W'(KERNEL - 2);

    state_t           state, state_nxt;
    logic [COL_W-1:0] w_r, h_r;
    logic [COL_W-1:0] col_cnt, row_cnt;
    logic             row_last, frame_last;
    logic             accept, cfg_bad, start_ok, load, out_fire, drain_done;

    assign cfg_bad    = (cfg_width == '0) || (cfg_height < KMIN);
    assign start_ok   = start && (state == S_IDLE) && !cfg_bad;
    assign accept     = in_valid && in_ready;
    assign stk_en     = accept;
    assign stk_col    = col_cnt;
    assign busy       = (state != S_IDLE);
    assign out_fire   = out_valid && out_ready;
    assign load       = accept && (state == S_RUN);
    assign drain_done = (state == S_DRAIN) && (!out_valid || out_ready);

    stack_pos_cnt #(.COL_W(COL_W)) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .inc        (accept),
        .width      (w_r),
        .height     (h_r),
        .col        (col_cnt),
        .row        (row_cnt),
        .row_last   (row_last),
        .frame_last (frame_last)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (accept && row_last && (row_cnt == FILL_ROW)) state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = !out_valid || out_ready;
                if (accept && frame_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            w_r        <= '0;
            h_r        <= '0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= drain_done;
            cfg_err    <= start && (state == S_IDLE) && cfg_bad;
            if (start_ok) begin
                w_r <= cfg_width;
                h_r <= cfg_height;
            end
            // a load in the same cycle as a drain keeps the stage full with the new column
            if (load) begin
                out_valid <= 1'b1;
                out_col   <= col_cnt;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STACK_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else begin
            if (busy && !in_valid && in_ready && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (out_valid && !out_ready && (bp_cnt != 16'hFFFF))
                bp_cnt <= bp_cnt + 16'd1;
        end
    end
`endif
endmodule
